// File: rtl/bp_table_scheduler.sv
// One-bit branch predictor table with a single access port shared between
// lookups and resolves. A small arbiter in IDLE picks which request is served,
// favouring resolves but bounding how long a waiting lookup can be starved.
module bp_table_scheduler #(
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_addr,
  output logic             pred_valid,
  output logic             pred,
  input  logic             rs_valid,
  output logic             rs_ready,
  input  logic [IDX_W-1:0] rs_addr,
  input  logic             rs_outcome,
  output logic             miss_pulse,
  output logic [3:0]       miss_cnt,
  output logic             busy
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned SC_W    = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LKUP    = 2'd1,
    S_UPD_CMP = 2'd2,
    S_UPD_WR  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ENTRIES-1:0] pred_tbl;
  logic [IDX_W-1:0]   addr_q;
  logic               outcome_q;
  logic               miss_flag_q;
  logic [SC_W-1:0]    starve_cnt;
  logic               rs_grant_c;
  logic               lk_grant_c;

  // Arbitration: resolve wins unless a waiting lookup has been starved long enough
  always_comb begin
    rs_grant_c = 1'b0;
    lk_grant_c = 1'b0;
    if (!reset && state == S_IDLE) begin
      if (rs_valid && (!lk_valid || starve_cnt < SC_W'(STARVE_LIM))) begin
        rs_grant_c = 1'b1;
      end else if (lk_valid) begin
        lk_grant_c = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rs_grant_c) begin
          state_nxt = S_UPD_CMP;
        end else if (lk_grant_c) begin
          state_nxt = S_LKUP;
        end
      end
      S_LKUP:    state_nxt = S_IDLE;
      S_UPD_CMP: state_nxt = S_UPD_WR;
      S_UPD_WR:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and the latched request
  always_comb begin
    lk_ready   = lk_grant_c;
    rs_ready   = rs_grant_c;
    busy       = (state != S_IDLE);
    pred_valid = 1'b0;
    pred       = 1'b0;
    miss_pulse = 1'b0;
    if (state == S_LKUP) begin
      pred_valid = 1'b1;
      pred       = pred_tbl[addr_q];
    end
    if (state == S_UPD_WR) begin
      miss_pulse = miss_flag_q;
    end
  end

  // Request latch, mismatch compare, table write and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_tbl    <= '0;
      addr_q      <= '0;
      outcome_q   <= 1'b0;
      miss_flag_q <= 1'b0;
      starve_cnt  <= '0;
      miss_cnt    <= 4'd0;
    end else begin
      if (rs_grant_c) begin
        addr_q    <= rs_addr;
        outcome_q <= rs_outcome;
        if (lk_valid && starve_cnt < SC_W'(STARVE_LIM)) begin
          starve_cnt <= starve_cnt + SC_W'(1);
        end
      end else if (lk_grant_c) begin
        addr_q     <= lk_addr;
        starve_cnt <= '0;
      end
      if (state == S_UPD_CMP) begin
        miss_flag_q <= pred_tbl[addr_q] ^ outcome_q;
      end
      if (state == S_UPD_WR) begin
        pred_tbl[addr_q] <= outcome_q;
        if (miss_flag_q) begin
          miss_cnt <= miss_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Bench for bp_table_scheduler: a transaction-level model (table array plus a
// countdown for the current operation) predicts every output each cycle.
module tb_bp_table_scheduler;

  localparam int IDX_W = 3;
  localparam int LIM   = 3;
  localparam int ENT   = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lk_valid = 1'b0;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_addr = '0;
  logic             pred_valid;
  logic             pred;
  logic             rs_valid = 1'b0;
  logic             rs_ready;
  logic [IDX_W-1:0] rs_addr = '0;
  logic             rs_outcome = 1'b0;
  logic             miss_pulse;
  logic [3:0]       miss_cnt;
  logic             busy;

  always #5 clk = ~clk;

  bp_table_scheduler #(.IDX_W(IDX_W), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr),
    .pred_valid(pred_valid), .pred(pred),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_addr(rs_addr), .rs_outcome(rs_outcome),
    .miss_pulse(miss_pulse), .miss_cnt(miss_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Behavioural model: table contents, remaining busy cycles of the current op
  bit mtab[ENT];
  int busy_left = 0;
  int starve = 0;
  int mcnt = 0;
  bit op_lk, op_pred, op_miss, op_out;
  int op_addr;
  bit lk_acc, rs_acc;

  function automatic bit m_rs_grant();
    return !reset && busy_left == 0 && rs_valid && (!lk_valid || starve < LIM);
  endfunction

  function automatic bit m_lk_grant();
    return !reset && busy_left == 0 && lk_valid && !m_rs_grant();
  endfunction

  // Model advance at every clock edge (or on reset)
  always @(posedge clk or posedge reset) begin
    lk_acc = 1'b0;
    rs_acc = 1'b0;
    if (reset) begin
      foreach (mtab[i]) mtab[i] = 1'b0;
      busy_left = 0; starve = 0; mcnt = 0;
      op_lk = 0; op_pred = 0; op_miss = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0 && !op_lk) begin
        mtab[op_addr] = op_out;
        if (op_miss) mcnt = (mcnt + 1) % 16;
      end
    end else if (m_rs_grant()) begin
      rs_acc = 1'b1;
      op_lk = 1'b0; op_addr = int'(rs_addr); op_out = rs_outcome;
      op_miss = mtab[op_addr] ^ rs_outcome;
      busy_left = 2;
      if (lk_valid && starve < LIM) starve++;
    end else if (m_lk_grant()) begin
      lk_acc = 1'b1;
      op_lk = 1'b1; op_pred = mtab[int'(lk_addr)];
      busy_left = 1;
      starve = 0;
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    chk("lk_ready",   32'(lk_ready),   32'(m_lk_grant()));
    chk("rs_ready",   32'(rs_ready),   32'(m_rs_grant()));
    chk("busy",       32'(busy),       32'(busy_left > 0));
    chk("pred_valid", 32'(pred_valid), 32'(busy_left > 0 && op_lk));
    chk("pred",       32'(pred),       32'(busy_left > 0 && op_lk && op_pred));
    chk("miss_pulse", 32'(miss_pulse), 32'(busy_left == 1 && !op_lk && op_miss));
    chk("miss_cnt",   32'(miss_cnt),   32'(mcnt));
    chk("ready_excl", 32'(lk_ready && rs_ready), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input int a, output bit p);
    lk_valid = 1'b1;
    lk_addr  = IDX_W'(a);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (lk_acc) break;
    end
    chk("lk_accept_timeout", 32'(lk_acc), 32'd1);
    lk_valid = 1'b0;
    @(negedge clk);
    chk("lk_pv_next_cycle", 32'(pred_valid), 32'd1);
    chk("lk_busy_during", 32'(busy), 32'd1);
    p = pred;
    @(negedge clk);
    chk("lk_busy_after", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic do_resolve(input int a, input bit o, output int bcyc, output bit saw);
    rs_valid   = 1'b1;
    rs_addr    = IDX_W'(a);
    rs_outcome = o;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (rs_acc) break;
    end
    chk("rs_accept_timeout", 32'(rs_acc), 32'd1);
    rs_valid = 1'b0;
    bcyc = 0;
    saw  = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (miss_pulse) saw = 1'b1;
      if (!busy) break;
      bcyc++;
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    bit    p, saw;
    int    bc;
    string seq;

    // Reset behaviour: requests during reset must not be granted
    lk_valid = 1'b1;
    rs_valid = 1'b1;
    @(negedge clk);
    chk("reset_lk_ready", 32'(lk_ready), 32'd0);
    chk("reset_rs_ready", 32'(rs_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    lk_valid = 1'b0;
    rs_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Fresh table predicts not-taken
    do_lookup(5, p);
    chk("first_lookup_pred", 32'(p), 32'd0);

    // Mispredicting resolve then lookup sees the update
    do_resolve(5, 1'b1, bc, saw);
    chk("resolve1_miss", 32'(saw), 32'd1);
    chk("resolve1_cnt", 32'(miss_cnt), 32'd1);
    do_lookup(5, p);
    chk("lookup_after_update", 32'(p), 32'd1);

    // Correct prediction: no miss, two busy cycles after acceptance
    do_resolve(5, 1'b1, bc, saw);
    chk("resolve2_nomiss", 32'(saw), 32'd0);
    chk("resolve2_cnt", 32'(miss_cnt), 32'd1);
    chk("resolve2_busy_cycles", 32'(bc), 32'd2);

    // Both requesters held: starvation limit forces R,R,R,L pattern
    seq = "";
    lk_valid = 1'b1; lk_addr = 3'd1;
    rs_valid = 1'b1; rs_addr = 3'd6; rs_outcome = 1'b1;
    for (int n = 0; n < 60 && seq.len() < 8; n++) begin
      tick();
      if (rs_acc) seq = {seq, "R"};
      if (lk_acc) seq = {seq, "L"};
    end
    lk_valid = 1'b0;
    rs_valid = 1'b0;
    checks++;
    if (seq != "RRRLRRRL") begin
      errors++;
      $display("FAIL grant_order got %s expected RRRLRRRL", seq);
    end
    repeat (4) tick();

    // Sixteen mispredicts wrap the counter
    do_reset();
    for (int k = 0; k < 16; k++) begin
      do_resolve(k % ENT, (k < ENT), bc, saw);
      if (k == 7) chk("miss_cnt_8", 32'(miss_cnt), 32'd8);
    end
    chk("miss_cnt_wrap", 32'(miss_cnt), 32'd0);

    // Reset during the compare step aborts the update
    do_reset();
    rs_valid = 1'b1; rs_addr = 3'd2; rs_outcome = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (rs_acc) break;
    end
    chk("abort_accept", 32'(rs_acc), 32'd1);
    rs_valid = 1'b0;
    reset = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (miss_pulse) saw = 1'b1;
    end
    chk("abort_no_miss", 32'(saw), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    do_lookup(2, p);
    chk("abort_entry", 32'(p), 32'd0);
    chk("abort_cnt", 32'(miss_cnt), 32'd0);

    // Randomized traffic with requesters holding until accepted
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (lk_acc) lk_valid = 1'b0;
      if (rs_acc) rs_valid = 1'b0;
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        reset = 1'b1;
      end
      if (!lk_valid && $urandom_range(2) == 0) begin
        lk_valid = 1'b1;
        lk_addr  = IDX_W'($urandom_range(ENT - 1));
      end
      if (!rs_valid && $urandom_range(2) == 0) begin
        rs_valid   = 1'b1;
        rs_addr    = IDX_W'($urandom_range(ENT - 1));
        rs_outcome = 1'($urandom_range(1));
      end
    end
    lk_valid = 1'b0;
    rs_valid = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
